mac_psum_accumulator: RTL and testbench

- Sits directly downstream of the dual 8-bit MAC (32-bit signed `result`, fixed pipeline latency, no stall capability).
- Tracks which MAC issue slots carry valid data and group boundaries, and accumulates the MAC results of each group into a wide partial sum.
- Buffers completed sums behind a valid/ready handshake toward the output/drain stage.
- Provides credit-based backpressure to the operand issuer, because the MAC pipeline itself cannot stall.

---
 rtl/mac_psum_accumulator.sv | 144 ++++++++++++++
 tb/tb_mac_psum_accumulator.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_psum_accumulator.sv
// Groups MAC results into wide partial sums, queues them in a small FWFT FIFO and issues
// credit-based backpressure. Define ACC_SATURATE_EN to clamp instead of wrap on overflow.
module mac_psum_accumulator #(
    parameter int unsigned MAC_LATENCY = 3,
    parameter int unsigned ACC_WIDTH   = 40,
    parameter int unsigned OUT_DEPTH   = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        ivalid,
    input  logic                        ilast,
    output logic                        oready,
    input  logic signed [31:0]          mac_result,
    output logic                        ovalid,
    input  logic                        iready,
    output logic signed [ACC_WIDTH-1:0] result
);

    localparam int unsigned PtrW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(OUT_DEPTH + 1);
    localparam int unsigned LifW = $clog2(MAC_LATENCY + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(OUT_DEPTH - 1);

    logic [MAC_LATENCY-1:0]      tag_v_q, tag_v_d;
    logic [MAC_LATENCY-1:0]      tag_l_q, tag_l_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                        first_q, first_d;
    logic signed [ACC_WIDTH-1:0] mem_q [OUT_DEPTH];
    logic signed [ACC_WIDTH-1:0] mem_d [OUT_DEPTH];
    logic [PtrW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]             count_q, count_d;
    logic                        rst_done_q, rst_done_d;

    logic                        accept;
    logic                        al_v;
    logic                        al_l;
    logic                        push;
    logic                        pop;
    logic [LifW-1:0]             lif;
    logic signed [ACC_WIDTH-1:0] ext;
    logic signed [ACC_WIDTH-1:0] base;
    logic signed [ACC_WIDTH-1:0] acc_next;

    assign al_v   = tag_v_q[MAC_LATENCY-1];
    assign al_l   = tag_l_q[MAC_LATENCY-1];
    assign push   = al_v && al_l;
    assign ovalid = (count_q != '0);
    assign pop    = ovalid && iready;
    assign accept = ivalid && oready;
    assign result = ovalid ? mem_q[rd_ptr_q] : '0;

    // Credits cover sums already queued plus group closes still inside the MAC pipe.
    always_comb begin
        lif = '0;
        for (int i = 0; i < MAC_LATENCY; i++) begin
            lif = lif + LifW'(tag_l_q[i]);
        end
        oready = rst_done_q && ((32'(count_q) + 32'(lif)) < OUT_DEPTH);
    end

    always_comb begin
        ext  = ACC_WIDTH'(mac_result);
        base = first_q ? '0 : acc_q;
`ifdef ACC_SATURATE_EN
        begin
            logic signed [ACC_WIDTH-1:0] sum;
            sum = base + ext;
            if ((base[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) &&
                (sum[ACC_WIDTH-1] != base[ACC_WIDTH-1])) begin
                acc_next = base[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                             : {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end else begin
                acc_next = sum;
            end
        end
`else
        acc_next = base + ext;
`endif
    end

    always_comb begin
        tag_v_d    = tag_v_q;
        tag_l_d    = tag_l_q;
        acc_d      = acc_q;
        first_d    = first_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rst_done_d = 1'b1;

        tag_v_d[0] = accept;
        tag_l_d[0] = accept && ilast;
        for (int i = 1; i < MAC_LATENCY; i++) begin
            tag_v_d[i] = tag_v_q[i-1];
            tag_l_d[i] = tag_l_q[i-1];
        end

        if (al_v) begin
            acc_d   = acc_next;
            first_d = al_l;
        end

        if (push) begin
            mem_d[wr_ptr_q] = acc_next;
            wr_ptr_d        = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tag_v_q    <= '0;
            tag_l_q    <= '0;
            acc_q      <= '0;
            first_q    <= 1'b1;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rst_done_q <= 1'b0;
        end else begin
            tag_v_q    <= tag_v_d;
            tag_l_q    <= tag_l_d;
            acc_q      <= acc_d;
            first_q    <= first_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rst_done_q <= rst_done_d;
        end
    end

endmodule

// File: tb/tb_mac_psum_accumulator.sv
// Directed bench: a 40-bit instance plus a 32-bit instance for the overflow boundary,
// both fed by a behavioural MAC delay line.
module tb_mac_psum_accumulator;

    localparam int unsigned Lat = 3;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               ivalid = 1'b0;
    logic               ilast = 1'b0;
    logic               iready = 1'b1;
    logic signed [31:0] op_val = '0;
    logic signed [31:0] mac_result;
    logic signed [31:0] dly [Lat];
    logic               oready, ovalid;
    logic signed [39:0] result;
    logic               oready32, ovalid32;
    logic signed [31:0] result32;

    int nvec = 0;
    int nerr = 0;

    always #5 clock = ~clock;

    // MAC model: the value presented with the operands appears Lat cycles later.
    always @(posedge clock) begin
        dly[0] <= op_val;
        for (int i = 1; i < Lat; i++) dly[i] <= dly[i-1];
    end
    assign mac_result = dly[Lat-1];

    mac_psum_accumulator #(.MAC_LATENCY(Lat), .ACC_WIDTH(40), .OUT_DEPTH(2)) dut (
        .clock(clock), .reset(reset), .ivalid(ivalid), .ilast(ilast), .oready(oready),
        .mac_result(mac_result), .ovalid(ovalid), .iready(iready), .result(result)
    );

    mac_psum_accumulator #(.MAC_LATENCY(Lat), .ACC_WIDTH(32), .OUT_DEPTH(2)) dut32 (
        .clock(clock), .reset(reset), .ivalid(ivalid), .ilast(ilast), .oready(oready32),
        .mac_result(mac_result), .ovalid(ovalid32), .iready(iready), .result(result32)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) step();
        @(negedge clock);
        nvec++; if (ovalid !== 1'b0) begin nerr++; $display("FAIL rst_ovalid: got %b want 0", ovalid); end
        nvec++; if (result !== 40'sd0) begin nerr++; $display("FAIL rst_result: got %0h want 0", result); end
        nvec++; if (oready !== 1'b0) begin nerr++; $display("FAIL rst_oready: got %b want 0", oready); end
        step();
        reset = 1'b0;
        nvec++; if (oready !== 1'b0) begin nerr++; $display("FAIL rel_oready0: got %b want 0", oready); end
        step();
        nvec++; if (oready !== 1'b1) begin nerr++; $display("FAIL rel_oready1: got %b want 1", oready); end
    endtask

    task automatic test_group4();
        int vals [4] = '{10, -3, 100, 7};
        for (int i = 0; i < 4; i++) begin
            ivalid = 1'b1; ilast = (i == 3); op_val = vals[i];
            nvec++; if (oready !== 1'b1) begin nerr++; $display("FAIL g4_oready[%0d]: got %b want 1", i, oready); end
            step();
        end
        ivalid = 1'b0; ilast = 1'b0; op_val = 32'sd0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock);
            if (i < 4) begin
                nvec++; if (ovalid !== 1'b0) begin nerr++; $display("FAIL g4_early[%0d]: got %b want 0", i, ovalid); end
            end else begin
                nvec++; if (ovalid !== 1'b1) begin nerr++; $display("FAIL g4_ovalid: got %b want 1", ovalid); end
                nvec++; if (result !== 40'sd114) begin nerr++; $display("FAIL g4_sum: got %0d want 114", result); end
            end
        end
    endtask

    task automatic test_back_to_back();
        step();
        ivalid = 1'b1; ilast = 1'b1; op_val = 32'sd5;
        nvec++; if (oready !== 1'b1) begin nerr++; $display("FAIL b2b_rdy0: got %b want 1", oready); end
        step();
        op_val = -32'sd9;
        nvec++; if (oready !== 1'b1) begin nerr++; $display("FAIL b2b_rdy1: got %b want 1", oready); end
        step();
        ivalid = 1'b0; ilast = 1'b0; op_val = 32'sd0;
        for (int j = 2; j <= 6; j++) begin
            @(negedge clock);
            if (j == 4) begin
                nvec++; if (ovalid !== 1'b1 || result !== 40'sd5) begin nerr++; $display("FAIL b2b_first: got v=%b %0d want v=1 5", ovalid, result); end
            end else if (j == 5) begin
                nvec++; if (ovalid !== 1'b1 || result !== -40'sd9) begin nerr++; $display("FAIL b2b_second: got v=%b %0d want v=1 -9", ovalid, result); end
            end else begin
                nvec++; if (ovalid !== 1'b0) begin nerr++; $display("FAIL b2b_idle[%0d]: got %b want 0", j, ovalid); end
            end
        end
    endtask

    task automatic test_credit();
        step();
        iready = 1'b0;
        ivalid = 1'b1; ilast = 1'b1; op_val = 32'sd11;
        nvec++; if (oready !== 1'b1) begin nerr++; $display("FAIL cr_rdyA: got %b want 1", oready); end
        step();
        op_val = 32'sd22;
        nvec++; if (oready !== 1'b1) begin nerr++; $display("FAIL cr_rdyB: got %b want 1", oready); end
        step();
        ivalid = 1'b0; op_val = 32'sd0;
        nvec++; if (oready !== 1'b0) begin nerr++; $display("FAIL cr_block: got %b want 0", oready); end
        repeat (5) step();
        nvec++; if (ovalid !== 1'b1 || result !== 40'sd11) begin nerr++; $display("FAIL cr_head: got v=%b %0d want v=1 11", ovalid, result); end
        nvec++; if (oready !== 1'b0) begin nerr++; $display("FAIL cr_full: got %b want 0", oready); end
        iready = 1'b1;
        step();
        iready = 1'b0;
        nvec++; if (oready !== 1'b1) begin nerr++; $display("FAIL cr_return: got %b want 1", oready); end
        nvec++; if (result !== 40'sd22) begin nerr++; $display("FAIL cr_head2: got %0d want 22", result); end
        ivalid = 1'b1; ilast = 1'b1; op_val = 32'sd33;
        step();
        ivalid = 1'b0; ilast = 1'b0; op_val = 32'sd0;
        nvec++; if (oready !== 1'b0) begin nerr++; $display("FAIL cr_block2: got %b want 0", oready); end
        repeat (4) step();
        iready = 1'b1;
        @(negedge clock);
        nvec++; if (ovalid !== 1'b1 || result !== 40'sd22) begin nerr++; $display("FAIL cr_order2: got v=%b %0d want v=1 22", ovalid, result); end
        step();
        @(negedge clock);
        nvec++; if (ovalid !== 1'b1 || result !== 40'sd33) begin nerr++; $display("FAIL cr_order3: got v=%b %0d want v=1 33", ovalid, result); end
        step();
        @(negedge clock);
        nvec++; if (ovalid !== 1'b0) begin nerr++; $display("FAIL cr_empty: got %b want 0", ovalid); end
    endtask

    task automatic test_gaps();
        logic        v [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int          d [5] = '{1, 32'h1234567, -999999, 2, 3};
        int          n;
        for (int i = 0; i < 5; i++) begin
            ivalid = v[i]; ilast = (i != 0) && (i != 3); op_val = d[i];
            step();
        end
        ivalid = 1'b0; ilast = 1'b0; op_val = 32'sd0;
        n = 0;
        do begin @(negedge clock); n++; end while (ovalid !== 1'b1 && n < 12);
        nvec++; if (ovalid !== 1'b1 || result !== 40'sd6) begin nerr++; $display("FAIL gap_sum: got v=%b %0d want v=1 6", ovalid, result); end
        nvec++; if (n != 4) begin nerr++; $display("FAIL gap_latency: got %0d want 4", n); end
        step();
    endtask

    task automatic test_overflow();
        int a [2] = '{32'h7FFFFFFF, 32'h80000000};
        int b [2] = '{1, -1};
        logic signed [39:0] e40 [2] = '{40'sh0080000000, 40'shFF7FFFFFFF};
`ifdef ACC_SATURATE_EN
        logic signed [31:0] e32 [2] = '{32'sh7FFFFFFF, 32'sh80000000};
`else
        logic signed [31:0] e32 [2] = '{32'sh80000000, 32'sh7FFFFFFF};
`endif
        int n;
        for (int k = 0; k < 2; k++) begin
            ivalid = 1'b1; ilast = 1'b0; op_val = a[k];
            step();
            ilast = 1'b1; op_val = b[k];
            step();
            ivalid = 1'b0; ilast = 1'b0; op_val = 32'sd0;
            n = 0;
            do begin @(negedge clock); n++; end while (ovalid32 !== 1'b1 && n < 12);
            nvec++; if (ovalid32 !== 1'b1 || result32 !== e32[k]) begin nerr++; $display("FAIL ovf32[%0d]: got v=%b %0h want v=1 %0h", k, ovalid32, result32, e32[k]); end
            nvec++; if (ovalid !== 1'b1 || result !== e40[k]) begin nerr++; $display("FAIL ovf40[%0d]: got v=%b %0h want v=1 %0h", k, ovalid, result, e40[k]); end
            step();
        end
    endtask

    task automatic test_reset_mid();
        int n;
        iready = 1'b0;
        ivalid = 1'b1; ilast = 1'b1; op_val = 32'sd50;
        step();
        ivalid = 1'b0; ilast = 1'b0; op_val = 32'sd0;
        repeat (3) step();
        ivalid = 1'b1; op_val = 32'sd1;
        step();
        op_val = 32'sd2;
        step();
        ivalid = 1'b0; op_val = 32'sd0;
        @(negedge clock);
        nvec++; if (ovalid !== 1'b1 || result !== 40'sd50) begin nerr++; $display("FAIL rm_queued: got v=%b %0d want v=1 50", ovalid, result); end
        step();
        reset = 1'b1;
        step();
        nvec++; if (ovalid !== 1'b0) begin nerr++; $display("FAIL rm_ovalid: got %b want 0", ovalid); end
        nvec++; if (result !== 40'sd0) begin nerr++; $display("FAIL rm_result: got %0d want 0", result); end
        nvec++; if (oready !== 1'b0) begin nerr++; $display("FAIL rm_oready: got %b want 0", oready); end
        reset = 1'b0; iready = 1'b1;
        step();
        nvec++; if (oready !== 1'b1) begin nerr++; $display("FAIL rm_rel: got %b want 1", oready); end
        ivalid = 1'b1; ilast = 1'b1; op_val = 32'sd42;
        step();
        ivalid = 1'b0; ilast = 1'b0; op_val = 32'sd0;
        n = 0;
        do begin @(negedge clock); n++; end while (ovalid !== 1'b1 && n < 12);
        nvec++; if (ovalid !== 1'b1 || result !== 40'sd42) begin nerr++; $display("FAIL rm_fresh: got v=%b %0d want v=1 42", ovalid, result); end
        step();
        repeat (4) step();
        nvec++; if (ovalid !== 1'b0) begin nerr++; $display("FAIL rm_nostale: got %b want 0", ovalid); end
    endtask

    initial begin
        test_reset();
        test_group4();
        test_back_to_back();
        test_credit();
        test_gaps();
        test_overflow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
